// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling-engine sequencer.
// Holds the FSM state encoding, the latched configuration record and the config sanity check.
package pool_pkg;

  localparam int POOL_DW = 16;

  localparam logic [POOL_DW-1:0] POOL_ZERO = {POOL_DW{1'b0}};
  localparam logic [POOL_DW-1:0] POOL_ONE  = {{(POOL_DW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } pool_seq_state_t;

  typedef struct packed {
    logic [POOL_DW-1:0] wid;
    logic [POOL_DW-1:0] hei;
    logic [POOL_DW-1:0] ch;
    logic [POOL_DW-1:0] kw;
    logic [POOL_DW-1:0] kh;
    logic [POOL_DW-1:0] sx;
    logic [POOL_DW-1:0] sy;
  } pool_cfg_t;

  // A window that is empty, never moves, or does not fit the input cannot be sequenced.
  function automatic logic pool_cfg_bad(input pool_cfg_t c);
    return (c.kw == POOL_ZERO) || (c.kh == POOL_ZERO) ||
           (c.sx == POOL_ZERO) || (c.sy == POOL_ZERO) ||
           (c.ch == POOL_ZERO) || (c.kw > c.wid) || (c.kh > c.hei);
  endfunction

endpackage

// File: rtl/pool_dim_calc.sv
// Counts how many pooling windows fit along one axis by stepping a window origin by the stride.
// done rises combinationally in the cycle the next origin no longer fits, and stays set.
module pool_dim_calc
  import pool_pkg::*;
#(
  parameter int DW = POOL_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] size,
  input  logic [DW-1:0] k,
  input  logic [DW-1:0] stride,
  input  logic          go,
  output logic [DW-1:0] count,
  output logic          done
);

  logic [DW+1:0] pos_r;
  logic [DW-1:0] count_r;
  logic          busy_r;
  logic          done_r;
  logic          fits_s;

  // Origin plus window compared two bits wider so it cannot wrap near the top of the range.
  always_comb begin
    fits_s = ((pos_r + {2'b00, k}) <= {2'b00, size});
  end

  assign done  = done_r | (busy_r & ~fits_s);
  assign count = count_r;

  // Stride-stepping window counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_r   <= {(DW+2){1'b0}};
      count_r <= {DW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (go) begin
      pos_r   <= {(DW+2){1'b0}};
      count_r <= {DW{1'b0}};
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else if (busy_r) begin
      if (fits_s) begin
        count_r <= count_r + {{(DW-1){1'b0}}, 1'b1};
        pos_r   <= pos_r + {2'b00, stride};
      end else begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_seq_ctrl.sv
// Pooling-engine sequencer: latches the pool config, sizes the output, then walks every window
// emitting one input-pixel coordinate per accepted beat in ch, oy, ox, ky, kx order.
module pool_seq_ctrl
  import pool_pkg::*;
#(
  parameter int DW = POOL_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] cfg_wid,
  input  logic [DW-1:0] cfg_hei,
  input  logic [DW-1:0] cfg_ch,
  input  logic [DW-1:0] cfg_kw,
  input  logic [DW-1:0] cfg_kh,
  input  logic [DW-1:0] cfg_sx,
  input  logic [DW-1:0] cfg_sy,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [DW-1:0] px_ch,
  output logic [DW-1:0] px_y,
  output logic [DW-1:0] px_x,
  output logic          win_first,
  output logic          win_last,
  output logic [DW-1:0] out_wid,
  output logic [DW-1:0] out_hei,
  output logic [DW-1:0] out_ch,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  pool_seq_state_t state_r, state_n;
  pool_cfg_t       cfg_r;
  logic            chk_r;
  logic            go_s, err_s, calc_ok_s, fire_s, final_s;
  logic            x_done_s, y_done_s;
  logic [DW-1:0]   x_cnt_s, y_cnt_s;

  logic [DW-1:0] kx_r, ky_r, ox_r, oy_r, ch_r, bx_r, by_r;
  logic [DW-1:0] kx_n, ky_n, ox_n, oy_n, ch_n, bx_n, by_n;
  logic          win_first_n, win_last_n;

  logic          px_valid_r, win_first_r, win_last_r;
  logic [DW-1:0] px_ch_r, px_y_r, px_x_r;
  logic [DW-1:0] out_wid_r, out_hei_r, out_ch_r;
  logic          busy_r, done_r, cfg_err_r;

  pool_dim_calc #(.DW(DW)) u_calc_x (
    .clk(clk), .rst(rst), .size(cfg_r.wid), .k(cfg_r.kw), .stride(cfg_r.sx),
    .go(go_s), .count(x_cnt_s), .done(x_done_s)
  );

  pool_dim_calc #(.DW(DW)) u_calc_y (
    .clk(clk), .rst(rst), .size(cfg_r.hei), .k(cfg_r.kh), .stride(cfg_r.sy),
    .go(go_s), .count(y_cnt_s), .done(y_done_s)
  );

  // Next-state logic; the first CALC cycle validates the config and launches both axis counters.
  always_comb begin
    state_n   = state_r;
    go_s      = 1'b0;
    err_s     = 1'b0;
    calc_ok_s = 1'b0;
    fire_s    = px_valid_r & px_ready;
    case (state_r)
      IDLE: begin
        if (start) state_n = CALC;
        else       state_n = IDLE;
      end
      CALC: begin
        if (chk_r) begin
          if (pool_cfg_bad(cfg_r)) begin
            err_s   = 1'b1;
            state_n = IDLE;
          end else begin
            go_s = 1'b1;
          end
        end else if (x_done_s && y_done_s) begin
          calc_ok_s = 1'b1;
          state_n   = RUN;
        end else begin
          state_n = CALC;
        end
      end
      RUN: begin
        if (fire_s && final_s) state_n = DONE;
        else                   state_n = RUN;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Beat walker: kx is innermost, channel outermost; window bases accumulate by stride.
  always_comb begin
    kx_n    = kx_r;
    ky_n    = ky_r;
    ox_n    = ox_r;
    oy_n    = oy_r;
    ch_n    = ch_r;
    bx_n    = bx_r;
    by_n    = by_r;
    final_s = 1'b0;
    if (kx_r != cfg_r.kw - POOL_ONE) begin
      kx_n = kx_r + POOL_ONE;
    end else begin
      kx_n = POOL_ZERO;
      if (ky_r != cfg_r.kh - POOL_ONE) begin
        ky_n = ky_r + POOL_ONE;
      end else begin
        ky_n = POOL_ZERO;
        if (ox_r != out_wid_r - POOL_ONE) begin
          ox_n = ox_r + POOL_ONE;
          bx_n = bx_r + cfg_r.sx;
        end else begin
          ox_n = POOL_ZERO;
          bx_n = POOL_ZERO;
          if (oy_r != out_hei_r - POOL_ONE) begin
            oy_n = oy_r + POOL_ONE;
            by_n = by_r + cfg_r.sy;
          end else begin
            oy_n = POOL_ZERO;
            by_n = POOL_ZERO;
            if (ch_r != cfg_r.ch - POOL_ONE) begin
              ch_n = ch_r + POOL_ONE;
            end else begin
              ch_n    = POOL_ZERO;
              final_s = 1'b1;
            end
          end
        end
      end
    end
    win_first_n = (kx_n == POOL_ZERO) && (ky_n == POOL_ZERO);
    win_last_n  = (kx_n == cfg_r.kw - POOL_ONE) && (ky_n == cfg_r.kh - POOL_ONE);
  end

  // Control state, latched config and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cfg_r     <= '{default: POOL_ZERO};
      chk_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      out_wid_r <= POOL_ZERO;
      out_hei_r <= POOL_ZERO;
      out_ch_r  <= POOL_ZERO;
    end else begin
      state_r <= state_n;
      chk_r   <= (state_r == IDLE) && start;
      busy_r  <= (state_n == CALC) || (state_n == RUN);
      done_r  <= (state_n == DONE);
      if ((state_r == IDLE) && start) begin
        cfg_r     <= '{wid: cfg_wid, hei: cfg_hei, ch: cfg_ch, kw: cfg_kw,
                       kh: cfg_kh, sx: cfg_sx, sy: cfg_sy};
        cfg_err_r <= 1'b0;
      end
      if (err_s) begin
        cfg_err_r <= 1'b1;
        out_wid_r <= POOL_ZERO;
        out_hei_r <= POOL_ZERO;
        out_ch_r  <= POOL_ZERO;
      end else if (calc_ok_s) begin
        out_wid_r <= x_cnt_s;
        out_hei_r <= y_cnt_s;
        out_ch_r  <= cfg_r.ch;
      end
    end
  end

  // Beat counters and the registered coordinate bus; everything holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {kx_r, ky_r, ox_r, oy_r, ch_r, bx_r, by_r} <= {(7*DW){1'b0}};
      px_valid_r  <= 1'b0;
      win_first_r <= 1'b0;
      win_last_r  <= 1'b0;
      px_ch_r     <= POOL_ZERO;
      px_y_r      <= POOL_ZERO;
      px_x_r      <= POOL_ZERO;
    end else if (calc_ok_s) begin
      {kx_r, ky_r, ox_r, oy_r, ch_r, bx_r, by_r} <= {(7*DW){1'b0}};
      px_valid_r  <= 1'b1;
      win_first_r <= 1'b1;
      win_last_r  <= (cfg_r.kw == POOL_ONE) && (cfg_r.kh == POOL_ONE);
      px_ch_r     <= POOL_ZERO;
      px_y_r      <= POOL_ZERO;
      px_x_r      <= POOL_ZERO;
    end else if (fire_s) begin
      kx_r        <= kx_n;
      ky_r        <= ky_n;
      ox_r        <= ox_n;
      oy_r        <= oy_n;
      ch_r        <= ch_n;
      bx_r        <= bx_n;
      by_r        <= by_n;
      px_valid_r  <= ~final_s;
      win_first_r <= win_first_n;
      win_last_r  <= win_last_n;
      px_ch_r     <= ch_n;
      px_y_r      <= by_n + ky_n;
      px_x_r      <= bx_n + kx_n;
    end
  end

  assign px_valid  = px_valid_r;
  assign px_ch     = px_ch_r;
  assign px_y      = px_y_r;
  assign px_x      = px_x_r;
  assign win_first = win_first_r;
  assign win_last  = win_last_r;
  assign out_wid   = out_wid_r;
  assign out_hei   = out_hei_r;
  assign out_ch    = out_ch_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Bench for pool_seq_ctrl: a nested-loop window model predicts every accepted beat,
// plus literal pins on chosen beats, latency, status registers and error handling.
module tb_pool_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, px_ready;
  logic [15:0] cfg_wid, cfg_hei, cfg_ch, cfg_kw, cfg_kh, cfg_sx, cfg_sy;
  logic        px_valid, win_first, win_last, busy, done, cfg_err;
  logic [15:0] px_ch, px_y, px_x, out_wid, out_hei, out_ch;

  int n_err = 0;
  int n_checks = 0;
  int beats_seen = 0;
  int done_seen = 0;
  bit valid_seen = 1'b0;
  bit tog_en = 1'b0;
  bit stall_prev = 1'b0;
  logic [49:0] held;
  logic [49:0] exp_q[$];
  logic [49:0] act_q[$];
  int m_ow, m_oh, m_total;
  bit m_bad;

  pool_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_wid(cfg_wid), .cfg_hei(cfg_hei), .cfg_ch(cfg_ch), .cfg_kw(cfg_kw),
    .cfg_kh(cfg_kh), .cfg_sx(cfg_sx), .cfg_sy(cfg_sy),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_ch(px_ch), .px_y(px_y), .px_x(px_x),
    .win_first(win_first), .win_last(win_last),
    .out_wid(out_wid), .out_hei(out_hei), .out_ch(out_ch),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Directly enumerate windows: base = o*stride, pixel = base + k.
  task automatic prep(input int w, input int h, input int c, input int kw, input int kh,
                      input int sx, input int sy);
    exp_q.delete();
    act_q.delete();
    beats_seen = 0;
    done_seen  = 0;
    valid_seen = 1'b0;
    m_bad = (kw == 0) || (kh == 0) || (sx == 0) || (sy == 0) || (c == 0) || (kw > w) || (kh > h);
    m_ow = 0;
    m_oh = 0;
    if (!m_bad) begin
      m_ow = (w - kw) / sx + 1;
      m_oh = (h - kh) / sy + 1;
      for (int ci = 0; ci < c; ci++)
        for (int oy = 0; oy < m_oh; oy++)
          for (int ox = 0; ox < m_ow; ox++)
            for (int ky = 0; ky < kh; ky++)
              for (int kx = 0; kx < kw; kx++)
                exp_q.push_back({16'(ci), 16'(oy * sy + ky), 16'(ox * sx + kx),
                                 (kx == 0) && (ky == 0), (kx == kw - 1) && (ky == kh - 1)});
    end
    m_total = exp_q.size();
    cfg_wid = 16'(w); cfg_hei = 16'(h); cfg_ch = 16'(c);
    cfg_kw = 16'(kw); cfg_kh = 16'(kh); cfg_sx = 16'(sx); cfg_sy = 16'(sy);
  endtask

  task automatic run_case(input int w, input int h, input int c, input int kw, input int kh,
                          input int sx, input int sy, input bit tog);
    int cyc;
    prep(w, h, c, kw, kh, sx, sy);
    tog_en = tog;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    if (m_bad) begin
      repeat (6) @(posedge clk);
      #1;
      chk("err_flag", cfg_err, 1);
      chk("err_no_valid", valid_seen, 0);
      chk("err_no_done", done_seen, 0);
      chk("err_busy", busy, 0);
      chk("err_out_wid", out_wid, 0);
      chk("err_out_hei", out_hei, 0);
      chk("err_out_ch", out_ch, 0);
    end else begin
      while (!px_valid && cyc < 400) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("latency", cyc, 3 + ((m_ow > m_oh) ? m_ow : m_oh));
      chk("err_cleared", cfg_err, 0);
      chk("busy_run", busy, 1);
      while (done_seen == 0 && cyc < 5000) begin
        @(posedge clk); #1;
        cyc++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("beat_total", beats_seen, m_total);
      chk("model_drained", exp_q.size(), 0);
      chk("done_once", done_seen, 1);
      chk("busy_idle", busy, 0);
      chk("valid_idle", px_valid, 0);
      chk("out_wid", out_wid, m_ow);
      chk("out_hei", out_hei, m_oh);
      chk("out_ch", out_ch, c);
    end
    tog_en = 1'b0;
  endtask

  // Ready pattern: steady high, or toggling every cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tog_en) px_ready = ~px_ready;
      else        px_ready = 1'b1;
    end
  end

  // Compare process: every accepted beat against the model, held values while stalled.
  initial begin
    logic [49:0] cur, exp_b;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (px_valid) begin
          valid_seen = 1'b1;
          cur = {px_ch, px_y, px_x, win_first, win_last};
          if (stall_prev) chk("stall_hold", cur, held);
          if (px_ready) begin
            act_q.push_back(cur);
            beats_seen++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL extra_beat: got beat %0h beyond expected %0d", cur, m_total);
            end else begin
              exp_b = exp_q.pop_front();
              chk("beat", cur, exp_b);
            end
          end
          stall_prev = !px_ready;
          held = cur;
        end else begin
          if (stall_prev) chk("stall_valid", px_valid, 1);
          stall_prev = 1'b0;
        end
        if (done) done_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; px_ready = 1'b1;
    cfg_wid = 16'd0; cfg_hei = 16'd0; cfg_ch = 16'd0; cfg_kw = 16'd0;
    cfg_kh = 16'd0; cfg_sx = 16'd0; cfg_sy = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", px_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_out", {out_wid, out_hei, out_ch}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_case(4, 4, 1, 2, 2, 2, 2, 1'b0);
    if (act_q.size() >= 5) begin
      chk("c1_beat0", act_q[0], {16'd0, 16'd0, 16'd0, 1'b1, 1'b0});
      chk("c1_beat3", act_q[3], {16'd0, 16'd1, 16'd1, 1'b0, 1'b1});
      chk("c1_beat4", act_q[4], {16'd0, 16'd0, 16'd2, 1'b1, 1'b0});
    end else begin
      chk("c1_beats_present", act_q.size(), 16);
    end
    chk("c1_out_wid", out_wid, 16'd2);

    run_case(5, 3, 1, 3, 3, 2, 1, 1'b0);
    chk("c2_out_wid", out_wid, 16'd2);
    chk("c2_out_hei", out_hei, 16'd1);
    if (act_q.size() >= 10) chk("c2_win2_base", act_q[9], {16'd0, 16'd0, 16'd2, 1'b1, 1'b0});
    else                    chk("c2_beats_present", act_q.size(), 18);

    run_case(4, 4, 1, 2, 2, 2, 2, 1'b1);
    run_case(4, 4, 1, 2, 2, 0, 2, 1'b0);
    run_case(4, 4, 1, 5, 2, 2, 2, 1'b0);

    // Reset while beat 7 of the 4x4 case is presented.
    prep(4, 4, 1, 2, 2, 2, 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (beats_seen < 7 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_reach_beat7", beats_seen, 7);
    chk("rst_err_cleared", cfg_err, 0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_valid", px_valid, 0);
    chk("midrst_out", {out_wid, out_hei, out_ch}, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_done", done_seen, 0);

    run_case(4, 4, 1, 2, 2, 2, 2, 1'b0);
    if (act_q.size() >= 1) chk("replay_beat0", act_q[0], {16'd0, 16'd0, 16'd0, 1'b1, 1'b0});
    else                   chk("replay_present", act_q.size(), 16);

    run_case(2, 2, 3, 1, 1, 1, 1, 1'b0);
    if (act_q.size() >= 9) begin
      chk("c6_beat3", act_q[3], {16'd0, 16'd1, 16'd1, 1'b1, 1'b1});
      chk("c6_beat4", act_q[4], {16'd1, 16'd0, 16'd0, 1'b1, 1'b1});
      chk("c6_beat8", act_q[8], {16'd2, 16'd0, 16'd0, 1'b1, 1'b1});
    end else begin
      chk("c6_beats_present", act_q.size(), 12);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
